spi_cfg_regfile: RTL
====================

SPI_CFG_REGFILE -- requirements
Module: spi_cfg_regfile

Interface
REQ-001 SHALL expose: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL expose: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL expose: sclk  input  1  SPI clock, asynchronous to clk, idle low (mode 0).
REQ-004 SHALL expose: copi  input  1  SPI controller-out data, asynchronous to clk.
REQ-005 SHALL expose: ncs  input  1  SPI chip select, active low, asynchronous to clk.
REQ-006 SHALL expose: en_reg_out_7_0  output  8  output-enable bits for outputs 7..0.
REQ-007 SHALL expose: en_reg_out_15_8  output  8  output-enable bits for outputs 15..8.
REQ-008 SHALL expose: en_reg_pwm_7_0  output  8  PWM-mode select bits for outputs 7..0.
REQ-009 SHALL expose: en_reg_pwm_15_8  output  8  PWM-mode select bits for outputs 15..8.
REQ-010 SHALL expose: pwm_duty_cycle  output  8  shared PWM duty value, 0x00 = 0%, 0xFF = 100%.
REQ-011 SHALL expose parameter: SYNC_STAGES, default 2, synchronizer depth for sclk/copi/ncs.

Function
REQ-012 Each of sclk, copi, ncs SHALL pass through SYNC_STAGES flops, then one history flop; edges are detected as current-synced vs history.
REQ-013 Frame format SHALL be 16 bits MSB first: bit15 R/W (1 = write), bits14:8 address, bits7:0 data.
REQ-014 copi SHALL be sampled on each synced sclk rising edge while synced ncs is low; the bit is shifted into a 16-bit shift register.
REQ-015 A 5-bit bit counter SHALL increment per sampled bit and saturate at 31.
REQ-016 Synced ncs falling edge SHALL clear the bit counter and shift register (start of frame).
REQ-017 Synced ncs rising edge SHALL commit the frame only when counter == 16 and bit15 == 1.
REQ-018 Commit address map: 0x00 en_reg_out_7_0, 0x01 en_reg_out_15_8, 0x02 en_reg_pwm_7_0, 0x03 en_reg_pwm_15_8, 0x04 pwm_duty_cycle.
REQ-019 Address 0x05..0x7F, read frames (bit15 == 0), short frames (<16 bits) and long frames (>16 bits) SHALL be discarded with no register change.
REQ-020 Commit latency: the target output SHALL change on the (SYNC_STAGES+1)th clk rising edge after the ncs rising edge at the pin, given setup met.
REQ-021 sclk edges while ncs is high SHALL be ignored.
REQ-022 Simultaneous synced ncs rising edge and sclk rising edge SHALL not sample the bit; commit decision uses the count before that edge.
REQ-023 Only one register SHALL be written per frame; all others hold.
REQ-024 Correct operation SHALL require clk frequency >= 4x sclk frequency; behaviour below that is undefined.

Reset
REQ-025 rst_n low SHALL asynchronously clear all five outputs to 0x00, shift register, bit counter, and all synchronizer/history flops; synchronizer flop reset state corresponds to ncs high (idle).
REQ-026 Reset mid-frame SHALL abort the frame; after release, a frame is recognised only after a fresh ncs falling edge.
REQ-027 Reset release SHALL be synchronous-deasserted externally; the block adds no deassertion logic.

Structure
REQ-028 Package spi_cfg_pkg SHALL hold FRAME_BITS = 16, ADDR_W = 7, address constants ADDR_EN_OUT_LO/HI, ADDR_EN_PWM_LO/HI, ADDR_DUTY, and MAX_ADDR = 0x04.
REQ-029 One sub-module, spi_sync_edge, SHALL implement one synchronizer chain plus history flop with rise/fall outputs; instantiated three times.
REQ-030 Shift register, counter and register file SHALL reside in spi_cfg_regfile itself.

Verification
REQ-031 Reset: assert rst_n = 0 mid-frame -> all outputs 0x00 immediately, no commit after release with ncs held low.
REQ-032 Write 0x80 0xF0 (addr 0, data 0xF0) -> en_reg_out_7_0 = 0xF0 exactly SYNC_STAGES+1 clk after ncs rise; others unchanged.
REQ-033 Write 0x84 0x80 -> pwm_duty_cycle = 0x80; then write 0x85 0x55 -> no output change.
REQ-034 Read frame 0x01 0xAA -> no change; 15-bit and 17-bit write frames to addr 0x02 -> en_reg_pwm_7_0 stays at prior value.
REQ-035 Toggle sclk 16 times with ncs high, then valid write 0x83 0x0F -> only en_reg_pwm_15_8 = 0x0F.
REQ-036 Back-to-back writes to addr 0x00..0x04 with 2 sclk gap between frames -> all five values committed in order.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared constants for the SPI configuration register file.
package spi_cfg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;
  localparam logic [ADDR_W-1:0] MAX_ADDR       = 7'h04;

endpackage

// File: rtl/spi_sync_edge.sv
// One asynchronous input brought into clk_sys domain: a STAGES-deep
// synchronizer followed by a history flop for edge detection.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Synchronizer chain plus history flop; reset value models the idle pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[STAGES-1];
    end
  end

  // Edge flags compare the synced level against the previous cycle's level.
  always_comb begin
    level = sync_q[STAGES-1];
    rise  = sync_q[STAGES-1] & ~hist_q;
    fall  = ~sync_q[STAGES-1] & hist_q;
  end

endmodule

// File: rtl/spi_cfg_regfile.sv
// SPI mode-0 write-only configuration register file. Frames are 16 bits,
// MSB first: R/W, 7-bit address, 8-bit data. A frame commits on ncs rise
// only if exactly 16 bits were clocked and it is a write to a mapped address.
module spi_cfg_regfile
  import spi_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic ncs_lvl,  ncs_rise,  ncs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .din(copi),
    .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .din(ncs),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, sclk_lvl, sclk_fall, copi_rise, copi_fall};

  logic [FRAME_BITS-1:0] shreg_q;
  logic [4:0]            bit_cnt_q;
  logic                  sample;
  logic                  commit;
  logic [ADDR_W-1:0]     frame_addr;
  logic [7:0]            frame_data;

  // A bit is taken only inside an active frame; ncs_lvl is already high on
  // the cycle its rise is flagged, so a coincident sclk rise is dropped.
  always_comb begin
    sample     = sclk_rise & ~ncs_lvl & ~ncs_rise;
    frame_addr = shreg_q[14:8];
    frame_data = shreg_q[7:0];
    commit     = ncs_rise && (bit_cnt_q == CNT_FULL) && shreg_q[15]
                 && (frame_addr <= MAX_ADDR);
  end

  // Frame shift register and saturating bit counter; ncs fall starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if (ncs_fall) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if (sample) begin
      shreg_q <= {shreg_q[FRAME_BITS-2:0], copi_lvl};
      if (bit_cnt_q != 5'd31) begin
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end
    end
  end

  // Register file: at most one target updated per committed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else if (commit) begin
      case (frame_addr)
        ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
        ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
        ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
        ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
        ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
        default: ;
      endcase
    end
  end

endmodule
